// File: rtl/matmul_arbiter.sv
// Round-robin arbiter/sequencer sharing one matrix multiplier among NREQ requesters.
// Validates dimensions, latches operands, runs the start/done handshake and a timeout watchdog.
module matmul_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAT_W   = 1152,
  parameter int TIMEOUT = 511
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       req_rowsA,
  input  logic [8*NREQ-1:0]       req_colsA,
  input  logic [8*NREQ-1:0]       req_colsB,
  input  logic [MAT_W*NREQ-1:0]   req_A,
  input  logic [MAT_W*NREQ-1:0]   req_B,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         rsp_valid,
  output logic                    rsp_err,
  output logic [MAT_W-1:0]        rsp_C,
  output logic                    busy,
  output logic                    mm_start,
  output logic [7:0]              mm_rowsA,
  output logic [7:0]              mm_colsA,
  output logic [7:0]              mm_colsB,
  output logic [MAT_W-1:0]        mm_Ain,
  output logic [MAT_W-1:0]        mm_Bin,
  input  logic [MAT_W-1:0]        mm_Cout,
  input  logic                    mm_done
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW1 = PW + 1;
  localparam int CW  = ($clog2(TIMEOUT + 1) > 9) ? $clog2(TIMEOUT + 1) : 9;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic            win_found;
  logic [NREQ-1:0] win_onehot;
  logic [CW-1:0]   count;
  logic [7:0]      win_rows, win_colsA, win_colsB;
  logic            dims_bad;
  logic            do_issue, do_reject, do_done, do_timeout;

  // Scan from the slot after the last served one, wrapping, so nobody starves.
  always_comb begin
    logic [PW1-1:0] idx;
    win       = ptr;
    win_found = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = {1'b0, ptr} + PW1'(i);
      if (idx >= PW1'(NREQ))
        idx = idx - PW1'(NREQ);
      if (!win_found && req[idx[PW-1:0]]) begin
        win       = idx[PW-1:0];
        win_found = 1'b1;
      end
    end
  end

  assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win;
  assign win_rows   = req_rowsA[win*8 +: 8];
  assign win_colsA  = req_colsA[win*8 +: 8];
  assign win_colsB  = req_colsB[win*8 +: 8];
  assign dims_bad   = (win_rows == 8'd0)  || (win_rows > 8'd6)  ||
                      (win_colsA == 8'd0) || (win_colsA > 8'd6) ||
                      (win_colsB == 8'd0) || (win_colsB > 8'd6);

  assign busy = (state != IDLE);

  always_comb begin
    state_next = state;
    do_issue   = 1'b0;
    do_reject  = 1'b0;
    do_done    = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          if (dims_bad) begin
            do_reject = 1'b1;
          end else begin
            do_issue   = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        // A done arriving on the timeout cycle still counts as a success.
        if (mm_done) begin
          do_done    = 1'b1;
          state_next = DRAIN;
        end else if (count == CW'(TIMEOUT)) begin
          do_timeout = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!mm_done)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= PW'(NREQ - 1);
      count     <= '0;
      grant     <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_C     <= '0;
      mm_start  <= 1'b0;
      mm_rowsA  <= '0;
      mm_colsA  <= '0;
      mm_colsB  <= '0;
      mm_Ain    <= '0;
      mm_Bin    <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      if (state == WAIT)
        count <= count + 1'b1;
      if (do_issue || do_reject)
        ptr <= win;
      if (do_reject) begin
        rsp_valid <= win_onehot;
        rsp_err   <= 1'b1;
      end
      if (do_issue) begin
        mm_rowsA <= win_rows;
        mm_colsA <= win_colsA;
        mm_colsB <= win_colsB;
        mm_Ain   <= req_A[win*MAT_W +: MAT_W];
        mm_Bin   <= req_B[win*MAT_W +: MAT_W];
        mm_start <= 1'b1;
        grant    <= win_onehot;
        count    <= '0;
      end
      if (do_done) begin
        rsp_C     <= mm_Cout;
        rsp_valid <= grant;
        mm_start  <= 1'b0;
        grant     <= '0;
      end
      if (do_timeout) begin
        rsp_valid <= grant;
        rsp_err   <= 1'b1;
        mm_start  <= 1'b0;
        grant     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_matmul_arbiter.sv
// Bench for matmul_arbiter: stub multiplier, vector table and a response scoreboard.
module tb_matmul_arbiter;

  localparam int NREQ    = 4;
  localparam int MAT_W   = 1152;
  localparam int TIMEOUT = 511;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [8*NREQ-1:0]     req_rowsA = '0, req_colsA = '0, req_colsB = '0;
  logic [MAT_W*NREQ-1:0] req_A = '0, req_B = '0;
  logic [NREQ-1:0]       grant, rsp_valid;
  logic                  rsp_err, busy, mm_start, mm_done;
  logic [MAT_W-1:0]      rsp_C, mm_Ain, mm_Bin, mm_Cout;
  logic [7:0]            mm_rowsA, mm_colsA, mm_colsB;

  always #5 clk = ~clk;

  matmul_arbiter #(.NREQ(NREQ), .MAT_W(MAT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_rowsA(req_rowsA), .req_colsA(req_colsA), .req_colsB(req_colsB),
    .req_A(req_A), .req_B(req_B),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_C(rsp_C),
    .busy(busy), .mm_start(mm_start),
    .mm_rowsA(mm_rowsA), .mm_colsA(mm_colsA), .mm_colsB(mm_colsB),
    .mm_Ain(mm_Ain), .mm_Bin(mm_Bin), .mm_Cout(mm_Cout), .mm_done(mm_done)
  );

  // Q20.12 row-major product, dense layout element (i,j) at index i*cols+j.
  function automatic logic [MAT_W-1:0] mat_mul(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b,
                                               input int r, input int k, input int c);
    logic [MAT_W-1:0] res;
    longint acc;
    res = '0;
    for (int i = 0; i < r; i++)
      for (int j = 0; j < c; j++) begin
        acc = 0;
        for (int t = 0; t < k; t++)
          acc += longint'($signed(a[(i*k+t)*32 +: 32])) * longint'($signed(b[(t*c+j)*32 +: 32]));
        acc = acc >>> 12;
        res[(i*c+j)*32 +: 32] = acc[31:0];
      end
    return res;
  endfunction

  // Stub multiplier: done after stub_lat cycles of start, held stub_hold cycles after start falls.
  int stub_lat = 3, stub_hold = 1, st_cnt = 0, hold_cnt = 0;
  bit stub_never = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st_cnt <= 0; hold_cnt <= 0; mm_done <= 1'b0; mm_Cout <= '0;
    end else if (mm_start) begin
      hold_cnt <= 0;
      if (!mm_done) begin
        if (!stub_never && st_cnt >= stub_lat) begin
          mm_done <= 1'b1;
          mm_Cout <= mat_mul(mm_Ain, mm_Bin, int'(mm_rowsA), int'(mm_colsA), int'(mm_colsB));
        end else begin
          st_cnt <= st_cnt + 1;
        end
      end
    end else begin
      st_cnt <= 0;
      if (mm_done) begin
        if (hold_cnt >= stub_hold) mm_done <= 1'b0;
        else hold_cnt <= hold_cnt + 1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NREQ-1:0]  valid;
    logic             err;
    logic [MAT_W-1:0] c;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int         idx;
    logic [7:0] r;
    logic [7:0] k;
    logic [7:0] c;
    logic       err;
  } vec_t;
  localparam int NV = 7;
  vec_t vecs[NV];

  int n_cmp = 0, n_bad = 0;
  logic [MAT_W-1:0] held_c = '0;
  bit saw_hold = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired, got no event expected one", name);
  endtask

  task automatic push_exp(input int idx, input bit err, input logic [MAT_W-1:0] prod);
    exp_t e;
    e.valid = '0;
    e.valid[idx] = 1'b1;
    e.err = err;
    if (err) e.c = held_c;
    else begin
      e.c = prod;
      held_c = prod;
    end
    sb.push_back(e);
  endtask

  task automatic compare_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_extra: got rsp_valid %b expected none", tag, rsp_valid);
      return;
    end
    e = sb.pop_front();
    check({tag, "_valid"}, 64'(rsp_valid), 64'(e.valid));
    check({tag, "_err"}, 64'(rsp_err), 64'(e.err));
    n_cmp++;
    if (rsp_C !== e.c) begin
      n_bad++;
      $display("FAIL %s_C: got low %h expected low %h", tag, rsp_C[127:0], e.c[127:0]);
    end
  endtask

  task automatic load_slot(input int idx, input int r, input int k, input int c,
                           output logic [MAT_W-1:0] prod);
    logic [MAT_W-1:0] a, b;
    for (int i = 0; i < 36; i++) begin
      a[i*32 +: 32] = $urandom_range(0, 32'hFFFF) - 32'h8000;
      b[i*32 +: 32] = $urandom_range(0, 32'hFFFF) - 32'h8000;
    end
    req_A[idx*MAT_W +: MAT_W] = a;
    req_B[idx*MAT_W +: MAT_W] = b;
    req_rowsA[idx*8 +: 8] = 8'(r);
    req_colsA[idx*8 +: 8] = 8'(k);
    req_colsB[idx*8 +: 8] = 8'(c);
    if (r >= 1 && r <= 6 && k >= 1 && k <= 6 && c >= 1 && c <= 6) prod = mat_mul(a, b, r, k, c);
    else prod = '0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((busy || mm_done) && t < 40) begin tick(); t++; end
    if (busy || mm_done) bound_fail({tag, "_idle"});
  endtask

  task automatic wait_rsps(input int n, input bit drop, input int budget, input string tag);
    int got = 0, t = 0, viol = 0;
    bit prev_start, prev_done;
    prev_start = mm_start;
    prev_done  = mm_done;
    while (got < n && t < budget) begin
      tick(); t++;
      if (!$onehot0(grant) || !$onehot0(rsp_valid)) viol++;
      if (rsp_valid == '0 && rsp_err) viol++;
      if (mm_start && !prev_start && prev_done) viol++;
      if (mm_done && !mm_start && busy) saw_hold = 1'b1;
      if (rsp_valid != '0) begin
        compare_rsp($sformatf("%s_r%0d", tag, got));
        got++;
        if (drop) req = req & ~rsp_valid;
      end
      prev_start = mm_start;
      prev_done  = mm_done;
    end
    check({tag, "_invariants"}, 64'(viol), 64'd0);
    if (got < n) begin
      bound_fail({tag, "_rsp"});
      sb.delete();
    end
  endtask

  logic [MAT_W-1:0] p, p0, p1, p2, p3, c1;
  int lat, t, tdone, t_issue, bad_g;
  bit saw_start, saw_busy, got1;

  initial begin
    vecs[0] = '{2, 8'd3, 8'd0, 8'd3, 1'b1};
    vecs[1] = '{2, 8'd3, 8'd3, 8'd7, 1'b1};
    vecs[2] = '{1, 8'd6, 8'd6, 8'd6, 1'b0};
    vecs[3] = '{3, 8'd1, 8'd1, 8'd1, 1'b0};
    vecs[4] = '{0, 8'd7, 8'd2, 8'd2, 1'b1};
    vecs[5] = '{2, 8'd2, 8'd4, 8'd5, 1'b0};
    vecs[6] = '{3, 8'd0, 8'd1, 8'd1, 1'b1};

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mm_start", 64'(mm_start), 64'd0);
    check("rst_mm_rowsA", 64'(mm_rowsA), 64'd0);

    // 2x2 A times identity from requester 0
    c1 = '0;
    c1[127:0] = 128'h00004000_00003000_00002000_00001000;
    req_A[0 +: MAT_W] = c1;
    req_B[0 +: MAT_W] = '0;
    req_B[127:0] = 128'h00001000_00000000_00000000_00001000;
    req_rowsA[7:0] = 8'd2; req_colsA[7:0] = 8'd2; req_colsB[7:0] = 8'd2;
    push_exp(0, 1'b0, c1);
    req[0] = 1'b1;
    tick();
    check("t1_start", 64'(mm_start), 64'd1);
    check("t1_grant", 64'(grant), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    req_A[0 +: MAT_W] = {36{32'hDEADBEEF}};
    t = 0; tdone = -1; bad_g = 0;
    while (rsp_valid == '0 && t < 100) begin
      tick(); t++;
      if (mm_done && tdone < 0) tdone = t;
      if (rsp_valid == '0 && grant != 4'b0001) bad_g++;
    end
    check("t1_grant_wait", 64'(bad_g), 64'd0);
    check("t1_rsp_latency", 64'(t), 64'(tdone + 1));
    check("t1_C_lo", rsp_C[63:0], 64'h00002000_00001000);
    check("t1_C_hi", rsp_C[127:64], 64'h00004000_00003000);
    compare_rsp("t1");
    req = '0;
    wait_idle("t1");

    // Single-request vector table, including dimension boundaries
    for (int v = 0; v < NV; v++) begin
      load_slot(vecs[v].idx, int'(vecs[v].r), int'(vecs[v].k), int'(vecs[v].c), p);
      push_exp(vecs[v].idx, vecs[v].err, p);
      req[vecs[v].idx] = 1'b1;
      lat = 0; saw_start = 0; saw_busy = 0; got1 = 0;
      while (!got1 && lat < 200) begin
        tick(); lat++;
        if (mm_start) saw_start = 1'b1;
        if (busy) saw_busy = 1'b1;
        if (rsp_valid != '0) got1 = 1'b1;
      end
      req = '0;
      if (!got1) begin
        bound_fail($sformatf("vec%0d", v));
        void'(sb.pop_front());
      end else begin
        compare_rsp($sformatf("vec%0d", v));
        check($sformatf("vec%0d_started", v), 64'(saw_start), 64'(!vecs[v].err));
        if (vecs[v].err) begin
          check($sformatf("vec%0d_rej_latency", v), 64'(lat), 64'd1);
          check($sformatf("vec%0d_rej_busy", v), 64'(saw_busy), 64'd0);
        end
      end
      wait_idle($sformatf("vec%0d", v));
    end

    // Round robin with all four held: order 0,1,2,3,0
    rst = 1'b1; tick(); rst = 1'b0; held_c = '0;
    load_slot(0, 3, 3, 3, p0);
    load_slot(1, 3, 3, 3, p1);
    load_slot(2, 3, 3, 3, p2);
    load_slot(3, 3, 3, 3, p3);
    push_exp(0, 1'b0, p0); push_exp(1, 1'b0, p1); push_exp(2, 1'b0, p2);
    push_exp(3, 1'b0, p3); push_exp(0, 1'b0, p0);
    req = 4'b1111;
    wait_rsps(5, 1'b0, 400, "rr");
    req = '0;
    wait_idle("rr");

    // Watchdog: stub never completes
    stub_never = 1'b1;
    load_slot(1, 2, 2, 2, p);
    push_exp(1, 1'b1, p);
    req[1] = 1'b1;
    t_issue = -1; t = 0;
    while (rsp_valid == '0 && t < 700) begin
      tick(); t++;
      if (mm_start && t_issue < 0) t_issue = cyc;
    end
    check("to_latency", 64'(cyc - t_issue), 64'd512);
    compare_rsp("to");
    req = '0;
    tick();
    check("to_start_low", 64'(mm_start), 64'd0);
    check("to_pulse_once", 64'(rsp_valid), 64'd0);
    wait_idle("to");
    stub_never = 1'b0;

    // Done held after start falls; requester 1 pending behind 0
    stub_lat = 2; stub_hold = 2; saw_hold = 1'b0;
    load_slot(0, 2, 3, 4, p0);
    load_slot(1, 4, 3, 2, p1);
    push_exp(0, 1'b0, p0); push_exp(1, 1'b0, p1);
    req = 4'b0011;
    wait_rsps(2, 1'b1, 200, "drain");
    check("drain_hold_seen", 64'(saw_hold), 64'd1);
    req = '0;
    wait_idle("drain");
    stub_hold = 1;

    // Asynchronous reset in the middle of WAIT
    stub_never = 1'b1;
    load_slot(2, 2, 2, 2, p2);
    req = 4'b0100;
    tick();
    check("rstw_issued", 64'(mm_start), 64'd1);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("rstw_grant", 64'(grant), 64'd0);
    check("rstw_start", 64'(mm_start), 64'd0);
    check("rstw_busy", 64'(busy), 64'd0);
    check("rstw_C", 64'(rsp_C != '0), 64'd0);
    check("rstw_mm_rowsA", 64'(mm_rowsA), 64'd0);
    stub_never = 1'b0;
    held_c = '0;
    @(posedge clk); #1 rst = 1'b0;
    load_slot(0, 2, 2, 2, p0);
    push_exp(0, 1'b0, p0); push_exp(2, 1'b0, p2);
    req = 4'b0101;
    tick();
    check("rstw_first_winner", 64'(grant), 64'd1);
    wait_rsps(2, 1'b1, 200, "rstw");
    req = '0;
    wait_idle("rstw");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not end, got hang expected finish");
    $fatal(1);
  end

endmodule
